// File: rtl/serial_pkg.sv
// Shared defaults, width helper and assembly-step decode for the serial deserializer.
package serial_pkg;

    localparam int DATA_W_DEFAULT     = 8;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Occupancy must represent DEPTH itself, hence one bit more than the pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [2:0] {
        ASM_HOLD,
        ASM_SHIFT,
        ASM_COMPLETE,
        ASM_ALIGN_BIT,
        ASM_ALIGN_IDLE
    } asm_op_t;

endpackage

// File: rtl/serial_deser_8bit_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO succeeds only if the head pops that cycle.
module sync_fifo
    import serial_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          nReset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop_req,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          valid,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = valid & pop_req;
    assign wr_en   = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are PTR_W wide so they wrap at DEPTH without extra logic.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_deser_8bit.sv
// Reassembles an MSB-first serial stream into words, buffers them and flags misalignment/overflow.
module serial_deser_8bit
    import serial_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                               clk,
    input  logic                               nReset,
    input  logic                               ser_in,
    input  logic                               ser_valid,
    input  logic                               frame_start,
    output logic [DATA_W-1:0]                  byte_out,
    output logic                               byte_valid,
    input  logic                               byte_ready,
    output logic [count_width(FIFO_DEPTH)-1:0] fifo_count,
    output logic                               overflow,
    output logic                               frame_err,
    input  logic                               clr_flags
);

    localparam int ACC_W = DATA_W - 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic [ACC_W-1:0]  acc;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] word;
    asm_op_t           op;
    logic              push;
    logic              misalign;
    logic              drop;

    // The low ACC_W bits of word are exactly the shifted accumulator.
    assign word     = {acc, ser_in};
    assign push     = (op == ASM_COMPLETE);
    assign misalign = frame_start & (bit_cnt != '0);

    always_comb begin
        op = ASM_HOLD;
        if (frame_start) begin
            op = ser_valid ? ASM_ALIGN_BIT : ASM_ALIGN_IDLE;
        end else if (ser_valid) begin
            op = (bit_cnt == LAST_BIT) ? ASM_COMPLETE : ASM_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else begin
            case (op)
                ASM_SHIFT: begin
                    acc     <= word[ACC_W-1:0];
                    bit_cnt <= bit_cnt + 1'b1;
                end
                ASM_COMPLETE: begin
                    acc     <= '0;
                    bit_cnt <= '0;
                end
                ASM_ALIGN_BIT: begin
                    acc     <= ACC_W'(ser_in);
                    bit_cnt <= BIT_W'(1);
                end
                ASM_ALIGN_IDLE: begin
                    acc     <= '0;
                    bit_cnt <= '0;
                end
                default: begin
                    acc     <= acc;
                    bit_cnt <= bit_cnt;
                end
            endcase
        end
    end

    // A set condition beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (misalign) begin
                frame_err <= 1'b1;
            end else if (clr_flags) begin
                frame_err <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nReset    (nReset),
        .push      (push),
        .push_data (word),
        .pop_req   (byte_ready),
        .rd_data   (byte_out),
        .valid     (byte_valid),
        .count     (fifo_count),
        .drop      (drop)
    );

endmodule

// File: tb/tb_serial_deser_8bit.sv
// Directed plus randomized bench comparing serial_deser_8bit against a bit-list/queue reference model.
module tb_serial_deser_8bit;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          ser_in = 1'b0;
    logic          ser_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic          byte_ready = 1'b0;
    logic          clr_flags = 1'b0;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          frame_err;

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: partial bit count/value, a byte queue, and the two sticky flags.
    int         part_n = 0;
    int         part_v = 0;
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_ferr = 1'b0;

    serial_deser_8bit #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .clr_flags   (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input bit rst_n, input bit sv, input bit si, input bit fs,
                             input bit rdy, input bit clr);
        bit         pop;
        bit         push;
        bit         set_ovf;
        bit         set_ferr;
        logic [7:0] w;
        if (!rst_n) begin
            part_n = 0;
            part_v = 0;
            q.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
            return;
        end
        pop      = (q.size() != 0) && rdy;
        push     = 1'b0;
        set_ovf  = 1'b0;
        set_ferr = 1'b0;
        w        = 8'h00;
        if (fs) begin
            set_ferr = (part_n != 0);
            part_n   = sv ? 1 : 0;
            part_v   = sv ? int'(si) : 0;
        end else if (sv) begin
            part_v = (part_v * 2 + int'(si)) % 256;
            part_n = part_n + 1;
            if (part_n == 8) begin
                push   = 1'b1;
                w      = 8'(part_v);
                part_n = 0;
                part_v = 0;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(w);
            else set_ovf = 1'b1;
        end
        m_ovf  = set_ovf  ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_ferr = set_ferr ? 1'b1 : (clr ? 1'b0 : m_ferr);
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".valid"}, 32'(byte_valid), 32'(q.size() != 0));
        chk({tag, ".data"},  32'(byte_out),   32'((q.size() != 0) ? q[0] : 8'h00));
        chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
        chk({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
        chk({tag, ".ferr"},  32'(frame_err),  32'(m_ferr));
    endtask

    // Inputs change at posedge+1 and outputs are sampled there, away from the active edge.
    task automatic applyStimulus(input bit rst_n, input bit sv, input bit si, input bit fs,
                                 input bit rdy, input bit clr, input string tag);
        nReset      = rst_n;
        ser_valid   = sv;
        ser_in      = si;
        frame_start = fs;
        byte_ready  = rdy;
        clr_flags   = clr;
        modelStep(rst_n, sv, si, fs, rdy, clr);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit fs, input bit rdy, input string tag);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b1, b[i], fs && (i == 7), rdy, 1'b0, tag);
        end
    endtask

    task automatic idle(input bit rdy, input bit clr, input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, rdy, clr, tag);
    endtask

    initial begin
        $display("[TB] start");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        chk("reset.count", 32'(fifo_count), 32'd0);
        chk("reset.valid", 32'(byte_valid), 32'd0);

        sendByte(8'hAA, 1'b1, 1'b0, "t1");
        chk("t1.data",  32'(byte_out),   32'hAA);
        chk("t1.count", 32'(fifo_count), 32'd1);
        chk("t1.flags", 32'({overflow, frame_err}), 32'd0);
        idle(1'b1, 1'b0, "t1.drain");

        sendByte(8'hA5, 1'b1, 1'b0, "t2");
        sendByte(8'h3C, 1'b0, 1'b0, "t2");
        chk("t2.count", 32'(fifo_count), 32'd2);
        chk("t2.head0", 32'(byte_out), 32'hA5);
        idle(1'b1, 1'b0, "t2.pop");
        chk("t2.head1", 32'(byte_out), 32'h3C);
        idle(1'b1, 1'b0, "t2.pop");
        chk("t2.empty", 32'(byte_valid), 32'd0);

        for (int b = 1; b <= 5; b++) sendByte(8'(b), 1'b0, 1'b0, "t3");
        chk("t3.count", 32'(fifo_count), 32'd4);
        chk("t3.ovf",   32'(overflow),   32'd1);
        for (int b = 1; b <= 4; b++) begin
            chk("t3.drain", 32'(byte_out), 32'(b));
            idle(1'b1, 1'b0, "t3.pop");
        end
        chk("t3.empty", 32'(byte_valid), 32'd0);
        idle(1'b0, 1'b1, "t3.clr");
        chk("t3.ovfclr", 32'(overflow), 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t4.part");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t4.part");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t4.part");
        sendByte(8'h81, 1'b1, 1'b0, "t4");
        chk("t4.ferr",  32'(frame_err),  32'd1);
        chk("t4.data",  32'(byte_out),   32'h81);
        chk("t4.count", 32'(fifo_count), 32'd1);
        idle(1'b1, 1'b1, "t4.clr");
        chk("t4.ferrclr", 32'(frame_err), 32'd0);

        for (int b = 0; b < 4; b++) sendByte(8'h10 + 8'(b), 1'b0, 1'b0, "t5.fill");
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'h7E;
            applyStimulus(1'b1, 1'b1, v[i], 1'b0, (i == 0), 1'b0, "t5");
        end
        chk("t5.count", 32'(fifo_count), 32'd4);
        chk("t5.ovf",   32'(overflow),   32'd0);
        chk("t5.head",  32'(byte_out),   32'h11);
        for (int b = 0; b < 3; b++) idle(1'b1, 1'b0, "t5.pop");
        chk("t5.last", 32'(byte_out), 32'h7E);
        idle(1'b1, 1'b0, "t5.pop");

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'(i), 1'b0, 1'b0, 1'b0, "t6.part");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "t6.rst");
        chk("t6.count", 32'(fifo_count), 32'd0);
        chk("t6.valid", 32'(byte_valid), 32'd0);
        chk("t6.flags", 32'({overflow, frame_err}), 32'd0);
        sendByte(8'hC3, 1'b1, 1'b0, "t6");
        chk("t6.data",  32'(byte_out),   32'hC3);
        chk("t6.count1", 32'(fifo_count), 32'd1);
        chk("t6.ferr",  32'(frame_err),  32'd0);

        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 9) < 7,
                          1'($urandom),
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 4,
                          $urandom_range(0, 19) == 0,
                          "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_deser_8bit.md
Name: serial_deser_8bit

Overview:
Downstream consumer of the 8-bit parallel-load shift register's serial output. It samples the MSB-first bit stream on qualified cycles, reassembles bytes, and buffers them in a small FIFO. The FIFO presents bytes to the next stage over a valid/ready handshake. The block also reports framing misalignment and FIFO overflow through sticky flags.

Parameters:
DATA_W, 8, bits per assembled word; legal range is DATA_W >= 2.
FIFO_DEPTH, 4, number of output FIFO entries; must be a power of two, >= 2.

Ports:
clk  input  1  clock; all state updates on posedge.
nReset  input  1  reset, synchronous, active-low.
ser_in  input  1  serial data, MSB first (driven by upstream data_out).
ser_valid  input  1  qualifies ser_in this cycle (high on upstream shift cycles).
frame_start  input  1  marks the start of a word; realigns the bit counter.
byte_out  output  DATA_W  FIFO head word.
byte_valid  output  1  FIFO non-empty.
byte_ready  input  1  consumer accepts head word this cycle.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
overflow  output  1  sticky: a completed word was dropped because the FIFO was full.
frame_err  output  1  sticky: frame_start arrived while a word was partially assembled.
clr_flags  input  1  clears overflow and frame_err.

Behaviour:
Reset (nReset low at posedge):
- acc, bit_cnt, the FIFO pointers/count, overflow and frame_err all go to 0.
- byte_valid=0, fifo_count=0, byte_out=0.
- A partial word in progress is discarded; the reset has priority over all other inputs.

Assembly:
- acc is DATA_W-1 bits; bit_cnt runs 0..DATA_W-1.
- When ser_valid=1 and frame_start=0:
  - If bit_cnt < DATA_W-1: acc <= {acc[DATA_W-3:0], ser_in}; bit_cnt++.
  - If bit_cnt == DATA_W-1: word = {acc, ser_in} is pushed; bit_cnt <= 0.
- When frame_start=1 and ser_valid=1: the current bit is the first bit of a new word. acc <= ser_in (zero-extended); bit_cnt <= 1.
- When frame_start=1 and ser_valid=0: bit_cnt <= 0.
- In either frame_start case, if bit_cnt != 0 beforehand, frame_err <= 1 and the partial word is discarded.
- ser_valid=0 and frame_start=0: hold.

FIFO (first-word-fall-through):
- byte_valid = (count != 0); byte_out = mem[rd_ptr], which is 0 when empty.
- pop = byte_valid & byte_ready.
- A pushed word is visible on byte_out and byte_valid the cycle after the edge that sampled the final bit; latency is 1 cycle.
- push & !full: write at wr_ptr; wr_ptr++ modulo FIFO_DEPTH.
- push & full & pop (same cycle): push is accepted; count is unchanged.
- push & full & !pop: word dropped, overflow <= 1, pointers unchanged.
- pop & empty: impossible by construction; byte_ready is ignored while byte_valid=0.
- Simultaneous push and pop when not full or empty: count is unchanged.
- Pointers wrap naturally at FIFO_DEPTH.

Flags:
- clr_flags=1 clears both flags.
- If a set condition and clr_flags occur in the same cycle, set wins.

Upstream shifting is not throttled. The FIFO is the only buffer; when it is full, data loss is flagged, never back-pressured.

Decomposition:
- Package serial_pkg holds DATA_W_DEFAULT=8, FIFO_DEPTH_DEFAULT=4, and a localparam function for the count width.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) covers storage, pointers, count, full/empty and the push-while-full-with-pop rule; it reports a drop pulse.
- The top level contains the assembly counter, acc, flag logic and instance wiring.

Test Plan:
1. Reset, then frame_start with the first bit, then 8 ser_valid bits of 0xAA MSB-first (1,0,1,0,1,0,1,0) with byte_ready=0 -> one cycle after the 8th bit: byte_valid=1, byte_out=0xAA, fifo_count=1; flags 0.
2. Bytes 0xA5 and 0x3C back-to-back with byte_ready=0, then byte_ready=1 -> fifo_count=2; pops in order 0xA5 then 0x3C; byte_valid=0 after the second pop.
3. 5 bytes (0x01..0x05) with byte_ready=0, FIFO_DEPTH=4 -> fifo_count=4, overflow=1; draining yields 0x01..0x04 only. clr_flags -> overflow=0.
4. 3 bits (1,1,0), then frame_start with 8 bits of 0x81 -> frame_err=1; the next byte out is 0x81, with no word from the partial bits.
5. FIFO full; 8th bit of 0x7E arrives on the same cycle as byte_ready=1 -> head popped, 0x7E accepted, fifo_count stays 4, overflow stays 0; 0x7E is the last byte drained.
6. nReset low after 5 bits of a word, then 8 bits of 0xC3 after frame_start -> after reset fifo_count=0, byte_valid=0, flags 0; the next output is exactly 0xC3.
